// File: rtl/vhT_pkg.sv
// rtl/vhT_pkg.sv - value_history_table entry layout, field extraction and prediction helpers
// Build option: VP_STRIDE_EN adds a per-entry stride and predicts last+stride.
package vhT_pkg;

   localparam int VHT_DATA_WIDTH = 32;
   localparam int VHT_PC_WIDTH   = 32;
   localparam int VHT_INDEX_BITS = 6;
   localparam int VHT_TAG_BITS   = 8;
   localparam int VHT_CONF_BITS  = 2;

   localparam logic [VHT_CONF_BITS-1:0] CONF_MAX = '1;

   typedef struct packed {
      logic                      valid;
      logic [VHT_TAG_BITS-1:0]   tag;
      logic [VHT_DATA_WIDTH-1:0] last;
      logic [VHT_CONF_BITS-1:0]  conf;
`ifdef VP_STRIDE_EN
      logic [VHT_DATA_WIDTH-1:0] stride;
`endif
   } vht_entry_t;

   // Word-aligned PCs: bits [1:0] never distinguish instructions.
   function automatic logic [VHT_INDEX_BITS-1:0] vht_index(input logic [VHT_PC_WIDTH-1:0] pc);
      return pc[VHT_INDEX_BITS+1:2];
   endfunction

   function automatic logic [VHT_TAG_BITS-1:0] vht_tag(input logic [VHT_PC_WIDTH-1:0] pc);
      return pc[VHT_INDEX_BITS+VHT_TAG_BITS+1:VHT_INDEX_BITS+2];
   endfunction

   function automatic logic [VHT_DATA_WIDTH-1:0] vht_pred_value(input vht_entry_t e);
`ifdef VP_STRIDE_EN
      return e.last + e.stride;
`else
      return e.last;
`endif
   endfunction

endpackage

// File: rtl/value_history_table_if.sv
// rtl/value_history_table_if.sv - lookup/resolve/prediction bundle between pipeline and predictor
interface value_history_table_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32
);
   logic                  i_Lookup_Valid;
   logic [PC_WIDTH-1:0]   i_Lookup_PC;
   logic                  i_Stall;
   logic                  i_Flush;
   logic                  i_Resolve_Valid;
   logic [PC_WIDTH-1:0]   i_Resolve_PC;
   logic [DATA_WIDTH-1:0] i_Resolve_Data;
   logic                  i_Resolve_Predicted;
   logic [DATA_WIDTH-1:0] i_Resolve_Pred_Data;
   logic                  o_Predict_Made;
   logic [DATA_WIDTH-1:0] o_Predicted_Data;
   logic                  o_Mispredict;
   logic [15:0]           o_Predict_Count;
   logic [15:0]           o_Mispredict_Count;

   modport master (
      output i_Lookup_Valid, i_Lookup_PC, i_Stall, i_Flush,
             i_Resolve_Valid, i_Resolve_PC, i_Resolve_Data,
             i_Resolve_Predicted, i_Resolve_Pred_Data,
      input  o_Predict_Made, o_Predicted_Data, o_Mispredict,
             o_Predict_Count, o_Mispredict_Count
   );

   modport slave (
      input  i_Lookup_Valid, i_Lookup_PC, i_Stall, i_Flush,
             i_Resolve_Valid, i_Resolve_PC, i_Resolve_Data,
             i_Resolve_Predicted, i_Resolve_Pred_Data,
      output o_Predict_Made, o_Predicted_Data, o_Mispredict,
             o_Predict_Count, o_Mispredict_Count
   );
endinterface

// File: rtl/vht_sat_counter.sv
// rtl/vht_sat_counter.sv - next-state logic of a saturating up/clear counter
// Clear wins over increment; the owner holds the register.
module vht_sat_counter #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] cur,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (clr) begin
         nxt = '0;
      end else if (inc && (cur != {WIDTH{1'b1}})) begin
         nxt = cur + WIDTH'(1);
      end
   end

endmodule

// File: rtl/value_history_table.sv
// rtl/value_history_table.sv - last-value/stride value predictor with registered EX-aligned output
// Build option: VP_STRIDE_EN enables stride storage and last+stride prediction.
module value_history_table
   import vhT_pkg::*;
#(
   parameter int DATA_WIDTH     = VHT_DATA_WIDTH,
   parameter int PC_WIDTH       = VHT_PC_WIDTH,
   parameter int INDEX_BITS     = VHT_INDEX_BITS,
   parameter int TAG_BITS       = VHT_TAG_BITS,
   parameter int CONF_BITS      = VHT_CONF_BITS,
   parameter int CONF_THRESHOLD = 2
) (
   input logic             i_Clk,
   input logic             i_Reset_n,
   value_history_table_if.slave bus
);

   localparam int DEPTH = 1 << INDEX_BITS;
   localparam logic [CONF_BITS-1:0] CONF_THR = CONF_BITS'(CONF_THRESHOLD);

   logic                  valid_q [DEPTH];
   logic [CONF_BITS-1:0]  conf_q  [DEPTH];
   logic [TAG_BITS-1:0]   tag_q   [DEPTH];
   logic [DATA_WIDTH-1:0] last_q  [DEPTH];
`ifdef VP_STRIDE_EN
   logic [DATA_WIDTH-1:0] stride_q [DEPTH];
`endif

   logic [INDEX_BITS-1:0] lk_idx, rs_idx;
   logic [TAG_BITS-1:0]   lk_tag, rs_tag;
   vht_entry_t            lk_ent, rs_ent;
   logic                  lk_hit;
   logic [DATA_WIDTH-1:0] lk_pred;
   logic                  rs_hit, rs_match;
   logic [DATA_WIDTH-1:0] rs_pred;
   logic [CONF_BITS-1:0]  conf_nxt;
   logic                  pcnt_inc;
   logic [15:0]           pcnt_nxt, mcnt_nxt;
   logic                  mispredict_d;

   assign lk_idx = vht_index(bus.i_Lookup_PC);
   assign lk_tag = vht_tag(bus.i_Lookup_PC);
   assign rs_idx = vht_index(bus.i_Resolve_PC);
   assign rs_tag = vht_tag(bus.i_Resolve_PC);

   // Both ports read the pre-update array contents: no write-to-read bypass.
   always_comb begin
      lk_ent        = '0;
      lk_ent.valid  = valid_q[lk_idx];
      lk_ent.tag    = tag_q[lk_idx];
      lk_ent.last   = last_q[lk_idx];
      lk_ent.conf   = conf_q[lk_idx];
`ifdef VP_STRIDE_EN
      lk_ent.stride = stride_q[lk_idx];
`endif
      rs_ent        = '0;
      rs_ent.valid  = valid_q[rs_idx];
      rs_ent.tag    = tag_q[rs_idx];
      rs_ent.last   = last_q[rs_idx];
      rs_ent.conf   = conf_q[rs_idx];
`ifdef VP_STRIDE_EN
      rs_ent.stride = stride_q[rs_idx];
`endif
   end

   assign lk_pred  = vht_pred_value(lk_ent);
   assign lk_hit   = bus.i_Lookup_Valid && lk_ent.valid && (lk_ent.tag == lk_tag)
                     && (lk_ent.conf >= CONF_THR);

   assign rs_pred  = vht_pred_value(rs_ent);
   assign rs_hit   = rs_ent.valid && (rs_ent.tag == rs_tag);
   assign rs_match = (bus.i_Resolve_Data == rs_pred);

   // A miss allocates with conf 0, so the clear path covers allocation too.
   vht_sat_counter #(.WIDTH(CONF_BITS)) u_conf (
      .cur (rs_ent.conf),
      .inc (rs_hit && rs_match),
      .clr (!(rs_hit && rs_match)),
      .nxt (conf_nxt)
   );

   assign pcnt_inc = !bus.i_Flush && !bus.i_Stall && lk_hit;

   vht_sat_counter #(.WIDTH(16)) u_pred_cnt (
      .cur (bus.o_Predict_Count),
      .inc (pcnt_inc),
      .clr (1'b0),
      .nxt (pcnt_nxt)
   );

   vht_sat_counter #(.WIDTH(16)) u_misp_cnt (
      .cur (bus.o_Mispredict_Count),
      .inc (bus.o_Mispredict),
      .clr (1'b0),
      .nxt (mcnt_nxt)
   );

   assign mispredict_d = bus.i_Resolve_Valid && bus.i_Resolve_Predicted
                         && (bus.i_Resolve_Data != bus.i_Resolve_Pred_Data);

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            conf_q[i]  <= '0;
         end
      end else if (bus.i_Resolve_Valid) begin
         valid_q[rs_idx] <= 1'b1;
         conf_q[rs_idx]  <= conf_nxt;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (bus.i_Resolve_Valid) begin
         tag_q[rs_idx]  <= rs_tag;
         last_q[rs_idx] <= bus.i_Resolve_Data;
`ifdef VP_STRIDE_EN
         if (!rs_hit) begin
            stride_q[rs_idx] <= '0;
         end else if (!rs_match) begin
            stride_q[rs_idx] <= bus.i_Resolve_Data - rs_ent.last;
         end
`endif
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         bus.o_Predict_Made     <= 1'b0;
         bus.o_Predicted_Data   <= '0;
         bus.o_Mispredict       <= 1'b0;
         bus.o_Predict_Count    <= '0;
         bus.o_Mispredict_Count <= '0;
      end else begin
         if (bus.i_Flush) begin
            bus.o_Predict_Made <= 1'b0;
         end else if (!bus.i_Stall) begin
            bus.o_Predict_Made   <= lk_hit;
            bus.o_Predicted_Data <= lk_hit ? lk_pred : '0;
         end
         bus.o_Mispredict       <= mispredict_d;
         bus.o_Predict_Count    <= pcnt_nxt;
         bus.o_Mispredict_Count <= mcnt_nxt;
      end
   end

endmodule
